// File: rtl/dmem_write_buffer.sv
// In-order store buffer between the core data port and a handshaked data memory.
// Optional macro WB_COALESCE_EN: stores hitting a queued non-head entry update it in place.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          wb_empty,
  output logic [CW-1:0] wb_count
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [29:0]   ent_addr_q [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic          hold_vld_q, hold_vld_d;
  logic [31:0]   hold_data_q, hold_data_d;

  logic [29:0]   cpu_word;
  logic          full, st_req, ld_req, ack;
  logic          fwd_hit, coal_hit, load_miss, do_enq, do_pop;
  logic [31:0]   fwd_data;
  logic [PW-1:0] coal_idx, head_nxt;
  logic          unused_addr_lsb;

  assign cpu_word        = cpu_addr[31:2];
  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign st_req          = cpu_we;
  assign ld_req          = cpu_re & ~cpu_we;
  assign full            = (count_q == CW'(DEPTH));
  assign ack             = mem_req_q & mem_ack;
  assign head_nxt        = head_q + 1'b1;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (ent_addr_q[head_q + PW'(i)] == cpu_word)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[head_q + PW'(i)];
      end
    end
  end

`ifdef WB_COALESCE_EN
  // The head may already be on the bus, so only entries behind it can absorb a store.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = head_q;
    for (int i = 1; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (ent_addr_q[head_q + PW'(i)] == cpu_word)) begin
        coal_hit = 1'b1;
        coal_idx = head_q + PW'(i);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = head_q;
`endif

  assign load_miss = ld_req & ~fwd_hit & ~hold_vld_q;
  assign do_enq    = st_req & ~full & ~coal_hit;
  assign do_pop    = (state_q == S_DRAIN) & ack;

  assign cpu_stall = (st_req & full & ~coal_hit) | load_miss;
  assign cpu_rdata = hold_vld_q ? hold_data_q : fwd_data;

  assign count_d = count_q + CW'(do_enq) - CW'(do_pop);
  assign tail_d  = do_enq ? tail_q + 1'b1 : tail_q;
  assign head_d  = do_pop ? head_nxt : head_q;

  always_ff @(posedge clk) begin
    if (do_enq) begin
      ent_addr_q[tail_q] <= cpu_word;
      ent_data_q[tail_q] <= cpu_wdata;
    end else if (st_req & coal_hit) begin
      ent_data_q[coal_idx] <= cpu_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_vld_d  = 1'b0;
    hold_data_d = hold_data_q;
    case (state_q)
      S_IDLE: begin
        if (load_miss) begin
          state_d    = S_LOAD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {cpu_word, 2'b00};
        end else if (count_q != '0) begin
          state_d     = S_DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {ent_addr_q[head_q], 2'b00};
          mem_wdata_d = ent_data_q[head_q];
        end
      end
      S_DRAIN: begin
        if (ack) begin
          if (load_miss) begin
            state_d    = S_LOAD;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_word, 2'b00};
          end else if (count_q > CW'(1)) begin
            mem_addr_d  = {ent_addr_q[head_nxt], 2'b00};
            mem_wdata_d = ent_data_q[head_nxt];
          end else begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (ack) begin
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          hold_vld_d  = 1'b1;
          hold_data_d = mem_rdata;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_count  = count_q;
  assign wb_empty  = (count_q == '0);

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer: vector table, directed corner cases,
// and randomized traffic checked against an architectural memory model.
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, reset;
  logic          cpu_we, cpu_re;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          wb_empty;
  logic [CW-1:0] wb_count;

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_empty(wb_empty), .wb_count(wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rd;
    logic [2:0]  cnt;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          ack_cyc = 0;
  bit          auto_ack = 0;
  bit          rnd_lat  = 0;
  int          fix_lat  = 0;
  int          cur_lat  = 0;
  txn_t        wlog[$];
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'd3 + 32'h1000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the memory completing the current request; ack is dropped after one edge.
  task automatic complete_txn();
    txn_t t;
    t.we = mem_we;
    t.a  = mem_addr;
    t.d  = mem_we ? mem_wdata : (mem_img.exists(mem_addr) ? mem_img[mem_addr] : init_val(mem_addr));
    if (mem_we) mem_img[mem_addr] = mem_wdata;
    else        mem_rdata = t.d;
    wlog.push_back(t);
    ack_cyc = cyc;
    mem_ack = 1'b1;
    cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : fix_lat;
  endtask

  // Memory responder; also checks that a pending request holds its fields.
  initial begin
    bit          pv;
    int          wcnt;
    logic [64:0] snap;
    mem_ack = 1'b0; mem_rdata = '0; pv = 0; wcnt = 0; snap = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        mem_ack = 1'b0; pv = 0; wcnt = 0;
      end else begin
        if (pv && !mem_ack) begin
          chk("req_held", mem_req, 1'b1);
          chk("fields_held", {mem_we, mem_addr, mem_wdata} ^ snap, 0);
        end
        if (mem_ack) begin
          mem_ack = 1'b0;
          wcnt = 0;
        end else if (mem_req && auto_ack) begin
          if (wcnt >= cur_lat) begin
            complete_txn();
            wcnt = 0;
          end else wcnt++;
        end
        pv   = mem_req && !mem_ack;
        snap = {mem_we, mem_addr, mem_wdata};
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0;
    auto_ack = 0; rnd_lat = 0; fix_lat = 0; cur_lat = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    wlog.delete();
  endtask

  task automatic wait_empty(input string nm, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (wb_empty) break;
      tick();
    end
    chk(nm, wb_empty, 1'b1);
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wlog.size()) chk(nm, {wlog[idx].we, wlog[idx].a, wlog[idx].d}, {1'b1, a, d});
    else chk({nm, "_missing"}, wlog.size(), idx + 1);
  endtask

  vec_t        vt[12];
  logic [31:0] arch[8];
  txn_t        exp_w[$];
  txn_t        wq[$];

  initial begin
    bit pending;
    int k, op;
    logic [31:0] d;

    // Reset state, checked before any clock edge.
    reset = 1'b1; cpu_we = 0; cpu_re = 0; cpu_addr = '0; cpu_wdata = '0;
    #2;
    chk("rst_count", wb_count, 0);
    chk("rst_empty", wb_empty, 1'b1);
    chk("rst_req", {mem_req, mem_we}, 0);
    chk("rst_addr_data", {mem_addr, mem_wdata}, 0);
    chk("rst_stall", cpu_stall, 1'b0);
    do_reset();

    // Table: ack held low, fill, forward, full-stall and (optional) coalesce.
    vt[0]  = '{1, 0, 32'h60, 32'h5,  0, 32'h0, 3'd1};
    vt[1]  = '{1, 0, 32'h60, 32'h9,  0, 32'h0, 3'd2};
    vt[2]  = '{0, 1, 32'h60, 32'h0,  0, 32'h9, 3'd2};
    vt[3]  = '{1, 0, 32'h64, 32'h3,  0, 32'h0, 3'd3};
    vt[4]  = '{0, 1, 32'h64, 32'h0,  0, 32'h3, 3'd3};
    vt[5]  = '{1, 0, 32'h68, 32'h4,  0, 32'h0, 3'd4};
    vt[6]  = '{0, 1, 32'h68, 32'h0,  0, 32'h4, 3'd4};
    vt[7]  = '{1, 0, 32'h6C, 32'h8,  1, 32'h0, 3'd4};
`ifdef WB_COALESCE_EN
    vt[8]  = '{1, 0, 32'h64, 32'h33, 0, 32'h0, 3'd4};
    vt[9]  = '{0, 1, 32'h64, 32'h0,  0, 32'h33, 3'd4};
`else
    vt[8]  = '{1, 0, 32'h64, 32'h33, 1, 32'h0, 3'd4};
    vt[9]  = '{0, 1, 32'h64, 32'h0,  0, 32'h3, 3'd4};
`endif
    vt[10] = '{0, 1, 32'h60, 32'h0,  0, 32'h9, 3'd4};
    vt[11] = '{0, 1, 32'h6B, 32'h0,  0, 32'h4, 3'd4};
    for (int i = 0; i < 12; i++) begin
      cpu_we = vt[i].we; cpu_re = vt[i].re; cpu_addr = vt[i].addr; cpu_wdata = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d_stall", i), cpu_stall, vt[i].stall);
      if (vt[i].re) chk($sformatf("vec%0d_rdata", i), cpu_rdata, vt[i].rd);
      tick();
      chk($sformatf("vec%0d_count", i), wb_count, vt[i].cnt);
    end
    cpu_we = 0; cpu_re = 0;
    chk("vec_head_on_bus", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h60, 32'h5});
    auto_ack = 1; fix_lat = 1;
    wait_empty("vec_drain", 60);
    chk("vec_no_reads", wlog.size(), 4);
    chk_wr("vec_wr0", 0, 32'h60, 32'h5);
    chk_wr("vec_wr1", 1, 32'h60, 32'h9);
`ifdef WB_COALESCE_EN
    chk_wr("vec_wr2", 2, 32'h64, 32'h33);
`else
    chk_wr("vec_wr2", 2, 32'h64, 32'h3);
`endif
    chk_wr("vec_wr3", 3, 32'h68, 32'h4);

    // Single store with a slow memory.
    do_reset();
    auto_ack = 1; fix_lat = 3; cur_lat = 3;
    cpu_we = 1; cpu_addr = 32'h64; cpu_wdata = 32'h7;
    #1;
    chk("single_stall", cpu_stall, 1'b0);
    tick();
    cpu_we = 0;
    chk("single_count", wb_count, 1);
    chk("single_req_next", mem_req, 1'b0);
    tick();
    chk("single_bus", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h64, 32'h7});
    wait_empty("single_drain", 40);
    chk("single_count0", wb_count, 0);
    chk("single_nwr", wlog.size(), 1);
    chk_wr("single_wr", 0, 32'h64, 32'h7);

    // Full buffer, one ack: stall holds through the ack cycle and drops after the pop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1; cpu_addr = 32'(i * 4); cpu_wdata = 32'h100 + 32'(i);
      #1;
      chk($sformatf("full_st%0d_stall", i), cpu_stall, 1'b0);
      tick();
    end
    cpu_addr = 32'h10; cpu_wdata = 32'h104;
    #1;
    chk("full_stall", cpu_stall, 1'b1);
    chk("full_count", wb_count, 4);
    complete_txn();
    #1;
    chk("full_stall_ack_cycle", cpu_stall, 1'b1);
    tick();
    #1;
    chk("full_stall_drop", cpu_stall, 1'b0);
    chk("full_count_pop", wb_count, 3);
    tick();
    cpu_we = 0;
    chk("full_count_enq", wb_count, 4);
    auto_ack = 1;
    wait_empty("full_drain", 60);
    for (int i = 0; i < 5; i++) chk_wr($sformatf("full_wr%0d", i), i, 32'(i * 4), 32'h100 + 32'(i));

    // Load miss behind an in-flight store.
    do_reset();
    mem_img[32'h80] = 32'hDEADBEEF;
    auto_ack = 1; fix_lat = 2; cur_lat = 2;
    cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
    tick();
    cpu_we = 0;
    tick();
    chk("miss_drain_busy", {mem_req, mem_we}, 2'b11);
    cpu_re = 1; cpu_addr = 32'h80;
    #1;
    chk("miss_stall", cpu_stall, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      #1;
      if (!cpu_stall) break;
    end
    chk("miss_unstall", cpu_stall, 1'b0);
    chk("miss_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("miss_ack_to_data", cyc - ack_cyc, 1);
    chk("miss_ntxn", wlog.size(), 2);
    chk_wr("miss_store_first", 0, 32'h20, 32'h55);
    if (wlog.size() > 1) chk("miss_read", {wlog[1].we, wlog[1].a}, {1'b0, 32'h80});
    cpu_re = 0;
    tick();

    // Reset while a write is on the bus.
    do_reset();
    cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1;
    tick();
    cpu_we = 0;
    tick();
    chk("rstmid_busy", mem_req, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("rstmid_req", mem_req, 1'b0);
    chk("rstmid_count", wb_count, 0);
    chk("rstmid_empty", wb_empty, 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstmid_idle%0d", i), mem_req, 1'b0);
    end

    // Coalescing pattern, ack held low.
    do_reset();
    cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1; tick();
    cpu_addr = 32'h70; cpu_wdata = 32'h1; tick();
    cpu_wdata = 32'h2;
    #1;
    chk("coal_stall", cpu_stall, 1'b0);
    tick();
    cpu_we = 0;
`ifdef WB_COALESCE_EN
    chk("coal_count", wb_count, 2);
`else
    chk("coal_count", wb_count, 3);
`endif
    auto_ack = 1; fix_lat = 0;
    wait_empty("coal_drain", 40);
    chk_wr("coal_wr0", 0, 32'h10, 32'h1);
`ifdef WB_COALESCE_EN
    chk("coal_nwr", wlog.size(), 2);
    chk_wr("coal_wr1", 1, 32'h70, 32'h2);
`else
    chk("coal_nwr", wlog.size(), 3);
    chk_wr("coal_wr1", 1, 32'h70, 32'h1);
    chk_wr("coal_wr2", 2, 32'h70, 32'h2);
`endif

    // Random traffic against an architectural view of memory.
    do_reset();
    auto_ack = 1; rnd_lat = 1;
    for (int i = 0; i < 8; i++) arch[i] = init_val(32'h200 + 32'(i * 4));
    exp_w.delete();
    pending = 0; k = 0; op = 0; d = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pending) begin
        op = int'($urandom_range(0, 2));
        k  = int'($urandom_range(0, 7));
        d  = $urandom;
        cpu_we = (op == 0); cpu_re = (op == 1);
        cpu_addr = 32'h200 + 32'(k * 4) + 32'($urandom_range(0, 3));
        cpu_wdata = d;
      end
      #1;
      if (!cpu_stall) begin
        if (cpu_we) begin
          arch[k] = d;
          exp_w.push_back('{1'b1, 32'h200 + 32'(k * 4), d});
        end else if (cpu_re) chk("rnd_load", cpu_rdata, arch[k]);
        pending = 0;
      end else pending = 1;
      if (wb_count > CW'(DEPTH)) chk("rnd_count_bound", wb_count, DEPTH);
      tick();
    end
    cpu_we = 0; cpu_re = 0;
    wait_empty("rnd_drain", 300);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = 32'h200 + 32'(i * 4);
      chk($sformatf("rnd_mem%0d", i), mem_img.exists(a) ? mem_img[a] : init_val(a), arch[i]);
    end
    wq.delete();
    foreach (wlog[i]) if (wlog[i].we) wq.push_back(wlog[i]);
`ifndef WB_COALESCE_EN
    chk("rnd_nwr", wq.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
      chk($sformatf("rnd_wr%0d", i), {wq[i].a, wq[i].d}, {exp_w[i].a, exp_w[i].d});
`else
    chk("rnd_nwr_le", (wq.size() <= exp_w.size()), 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
